// File: rtl/dla_filter_stream_reader_pkg.sv
// Shared types for the filter/bias stream reader: descriptor layout above the base address,
// FSM states and a burst clipping helper.
package dla_filter_stream_reader_pkg;

  localparam int unsigned NumWordsWidth   = 32;
  localparam int unsigned NumRepeatsWidth = 16;
  localparam int unsigned DescFieldsWidth = NumWordsWidth + NumRepeatsWidth;

  // Sits directly above the base address field in the config word.
  typedef struct packed {
    logic [NumRepeatsWidth-1:0] num_repeats;
    logic [NumWordsWidth-1:0]   num_words;
  } filter_reader_desc_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } fsm_state_e;

  function automatic logic [31:0] clip_burst(input logic [31:0] remaining,
                                             input logic [31:0] max_burst);
    return (remaining > max_burst) ? max_burst : remaining;
  endfunction

endpackage

// File: rtl/dla_filter_reader_fifo.sv
// Show-ahead FIFO for read responses. There is no full flag: the reader's credit scheme never
// lets more words be in flight than the FIFO can hold.
module dla_filter_reader_fifo #(
  parameter int unsigned Width = 512,
  parameter int unsigned Depth = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             empty_o
);

  localparam int unsigned PtrWidth   = $clog2(Depth);
  localparam int unsigned CountWidth = PtrWidth + 1;

  logic [Width-1:0]      mem_q [Depth];
  logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountWidth-1:0] count_q;
  logic                  rd_fire;

  assign empty_o   = (count_q == '0);
  assign rd_fire   = rd_en_i & ~empty_o;
  // Head word is presented combinationally; zero when empty keeps the output clean after reset.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CountWidth'(wr_en_i) - CountWidth'(rd_fire);
    end
  end

endmodule

// File: rtl/dla_filter_stream_reader.sv
// Filter/bias stream reader: turns one descriptor into credit-limited burst reads and streams the
// buffered responses out. Define DLA_FILTER_READER_PERF_COUNTERS_EN for starve/stall counters.
module dla_filter_stream_reader
  import dla_filter_stream_reader_pkg::*;
#(
  parameter int unsigned CONFIG_WIDTH        = 128,
  parameter int unsigned ADDR_WIDTH          = 32,
  parameter int unsigned FILTER_READER_WIDTH = 512,
  parameter int unsigned MAX_BURST           = 16,
  parameter int unsigned FIFO_DEPTH          = 64
) (
  input  logic                           clk,
  input  logic                           i_aresetn,
  input  logic [CONFIG_WIDTH-1:0]        i_config_data,
  input  logic                           i_config_valid,
  output logic                           o_config_ready,
  output logic [ADDR_WIDTH-1:0]          o_rd_addr,
  output logic [$clog2(MAX_BURST):0]     o_rd_burstcount,
  output logic                           o_rd_valid,
  input  logic                           i_rd_ready,
  input  logic [FILTER_READER_WIDTH-1:0] i_rd_data,
  input  logic                           i_rd_valid,
  output logic [FILTER_READER_WIDTH-1:0] o_filter_data,
  output logic                           o_filter_valid,
  input  logic                           i_filter_ready,
  output logic                           o_busy
`ifdef DLA_FILTER_READER_PERF_COUNTERS_EN
  ,
  output logic [31:0]                    o_pc_starve_cycles,
  output logic [31:0]                    o_pc_stall_cycles
`endif
);

  localparam int unsigned BurstWidth  = $clog2(MAX_BURST) + 1;
  localparam int unsigned CreditWidth = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ByteShift   = $clog2(FILTER_READER_WIDTH / 8);

  fsm_state_e                state_q;
  logic [ADDR_WIDTH-1:0]     base_q, addr_q, next_addr;
  logic [NumWordsWidth-1:0]  num_words_q, rem_q, next_rem;
  logic [NumRepeatsWidth-1:0] repeats_q;
  logic [BurstWidth-1:0]     burst_q, next_burst, first_burst;
  logic [CreditWidth-1:0]    credits_q, credits_d;
  logic                      rd_valid_q, config_ready_q, busy_q;
  logic                      cfg_fire, req_fire, pop, has_next, fifo_empty;

  filter_reader_desc_t   cfg_desc;
  logic [ADDR_WIDTH-1:0] cfg_base;

  assign cfg_base = i_config_data[ADDR_WIDTH-1:0];
  assign cfg_desc = filter_reader_desc_t'(i_config_data[ADDR_WIDTH +: DescFieldsWidth]);

  if (CONFIG_WIDTH > ADDR_WIDTH + DescFieldsWidth) begin : g_unused_cfg
    logic unused_cfg;
    assign unused_cfg = ^i_config_data[CONFIG_WIDTH-1:ADDR_WIDTH+DescFieldsWidth];
  end

  assign cfg_fire = i_config_valid & config_ready_q;
  assign req_fire = rd_valid_q & i_rd_ready;
  assign pop      = o_filter_valid & i_filter_ready;

  assign o_config_ready  = config_ready_q;
  assign o_rd_addr       = addr_q;
  assign o_rd_burstcount = burst_q;
  assign o_rd_valid      = rd_valid_q;
  assign o_busy          = busy_q;
  assign o_filter_valid  = ~fifo_empty;

  // Credits count FIFO slots not yet promised to an outstanding or buffered word.
  always_comb begin
    credits_d = credits_q - (req_fire ? CreditWidth'(burst_q) : '0) + CreditWidth'(pop);
  end

  // Request that follows the one currently presented: continue the pass, restart it, or stop.
  always_comb begin
    first_burst = BurstWidth'(clip_burst(cfg_desc.num_words, MAX_BURST));
    has_next    = 1'b1;
    next_addr   = addr_q + (ADDR_WIDTH'(burst_q) << ByteShift);
    next_burst  = burst_q;
    next_rem    = rem_q;
    if (rem_q != '0) begin
      next_burst = BurstWidth'(clip_burst(rem_q, MAX_BURST));
      next_rem   = rem_q - NumWordsWidth'(next_burst);
    end else if (repeats_q != '0) begin
      next_addr  = base_q;
      next_burst = BurstWidth'(clip_burst(num_words_q, MAX_BURST));
      next_rem   = num_words_q - NumWordsWidth'(next_burst);
    end else begin
      has_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q        <= StIdle;
      base_q         <= '0;
      addr_q         <= '0;
      num_words_q    <= '0;
      rem_q          <= '0;
      repeats_q      <= '0;
      burst_q        <= '0;
      rd_valid_q     <= 1'b0;
      config_ready_q <= 1'b0;
      busy_q         <= 1'b0;
      credits_q      <= CreditWidth'(FIFO_DEPTH);
    end else begin
      credits_q <= credits_d;
      unique case (state_q)
        StIdle: begin
          config_ready_q <= 1'b1;
          // An empty descriptor is consumed without leaving idle.
          if (cfg_fire && (cfg_desc.num_words != '0)) begin
            base_q         <= cfg_base;
            addr_q         <= cfg_base;
            num_words_q    <= cfg_desc.num_words;
            repeats_q      <= cfg_desc.num_repeats;
            burst_q        <= first_burst;
            rem_q          <= cfg_desc.num_words - NumWordsWidth'(first_burst);
            rd_valid_q     <= (credits_d >= CreditWidth'(first_burst));
            config_ready_q <= 1'b0;
            busy_q         <= 1'b1;
            state_q        <= StIssue;
          end
        end
        StIssue: begin
          if (req_fire) begin
            if (has_next) begin
              addr_q     <= next_addr;
              burst_q    <= next_burst;
              rem_q      <= next_rem;
              rd_valid_q <= (credits_d >= CreditWidth'(next_burst));
              if (rem_q == '0) begin
                repeats_q <= repeats_q - 1'b1;
              end
            end else begin
              rd_valid_q <= 1'b0;
              state_q    <= StDrain;
            end
          end else if (!rd_valid_q) begin
            rd_valid_q <= (credits_d >= CreditWidth'(burst_q));
          end
        end
        StDrain: begin
          if (credits_d == CreditWidth'(FIFO_DEPTH)) begin
            busy_q         <= 1'b0;
            config_ready_q <= 1'b1;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_aresetn) begin
      assert (credits_q <= CreditWidth'(FIFO_DEPTH));
      assert (!(req_fire && (credits_q < CreditWidth'(burst_q))));
    end
  end

  dla_filter_reader_fifo #(
    .Width (FILTER_READER_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (i_aresetn),
    .wr_en_i   (i_rd_valid),
    .wr_data_i (i_rd_data),
    .rd_en_i   (pop),
    .rd_data_o (o_filter_data),
    .empty_o   (fifo_empty)
  );

`ifdef DLA_FILTER_READER_PERF_COUNTERS_EN
  logic [31:0] starve_q, stall_q;

  always_ff @(posedge clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      starve_q <= '0;
      stall_q  <= '0;
    end else if (cfg_fire) begin
      starve_q <= '0;
      stall_q  <= '0;
    end else begin
      if (busy_q && !o_filter_valid && (starve_q != '1)) begin
        starve_q <= starve_q + 1'b1;
      end
      if (o_filter_valid && !i_filter_ready && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign o_pc_starve_cycles = starve_q;
  assign o_pc_stall_cycles  = stall_q;
`endif

endmodule

// File: tb/tb_dla_filter_stream_reader.sv
// Bench for dla_filter_stream_reader: directed descriptors with randomized handshakes, checked
// against a pass/burst reference list and an address-derived data pattern.
module tb_dla_filter_stream_reader;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 512;
  localparam int unsigned MAXB  = 4;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned CFGW  = 128;
  localparam int unsigned BCW   = $clog2(MAXB) + 1;
  localparam int unsigned WB    = DW / 8;

  logic            clk;
  logic            i_aresetn;
  logic [CFGW-1:0] i_config_data;
  logic            i_config_valid;
  logic            o_config_ready;
  logic [AW-1:0]   o_rd_addr;
  logic [BCW-1:0]  o_rd_burstcount;
  logic            o_rd_valid;
  logic            i_rd_ready;
  logic [DW-1:0]   i_rd_data;
  logic            i_rd_valid;
  logic [DW-1:0]   o_filter_data;
  logic            o_filter_valid;
  logic            i_filter_ready;
  logic            o_busy;
`ifdef DLA_FILTER_READER_PERF_COUNTERS_EN
  logic [31:0]     pc_starve, pc_stall;
`endif

  dla_filter_stream_reader #(
    .CONFIG_WIDTH        (CFGW),
    .ADDR_WIDTH          (AW),
    .FILTER_READER_WIDTH (DW),
    .MAX_BURST           (MAXB),
    .FIFO_DEPTH          (DEPTH)
  ) dut (
    .clk             (clk),
    .i_aresetn       (i_aresetn),
    .i_config_data   (i_config_data),
    .i_config_valid  (i_config_valid),
    .o_config_ready  (o_config_ready),
    .o_rd_addr       (o_rd_addr),
    .o_rd_burstcount (o_rd_burstcount),
    .o_rd_valid      (o_rd_valid),
    .i_rd_ready      (i_rd_ready),
    .i_rd_data       (i_rd_data),
    .i_rd_valid      (i_rd_valid),
    .o_filter_data   (o_filter_data),
    .o_filter_valid  (o_filter_valid),
    .i_filter_ready  (i_filter_ready),
    .o_busy          (o_busy)
`ifdef DLA_FILTER_READER_PERF_COUNTERS_EN
    ,
    .o_pc_starve_cycles (pc_starve),
    .o_pc_stall_cycles  (pc_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int outstanding = 0;
  int fifo_cnt = 0;
  int last_pop_cyc = 0;
  int rd_mode = 0;    // 0: i_rd_ready tied 1, 1: random
  int filt_mode = 0;  // 0: ready 1, 1: random, 2: held 0
  int rsp_mode = 0;   // 0: respond every cycle, 1: random gaps
  logic [31:0] salt;

  logic [AW-1:0] resp_q[$];
  logic [AW-1:0] got_req_addr[$];
  int            got_req_burst[$];
  logic [DW-1:0] got_word[$];
  logic [AW-1:0] exp_req_addr[$];
  int            exp_req_burst[$];
  logic [DW-1:0] exp_word[$];

  logic          req_pend, filt_pend;
  logic [AW-1:0] pend_addr;
  logic [BCW-1:0] pend_burst;
  logic [DW-1:0] pend_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory contents: a fixed function of the word address, so repeated passes return equal data.
  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    for (int j = 0; j < DW / 32; j++) begin
      d[j*32 +: 32] = (a * 32'h9E37_79B1) ^ (32'(j) * 32'h85EB_CA6B) ^ salt;
    end
    return d;
  endfunction

  // Handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!i_aresetn) begin
      outstanding = 0;
      fifo_cnt    = 0;
      req_pend    = 1'b0;
      filt_pend   = 1'b0;
    end else begin
      check("filter_valid_showahead", o_filter_valid, (fifo_cnt != 0));
      if (req_pend) begin
        check("req_hold_valid", o_rd_valid, 1'b1);
        check("req_hold_addr", o_rd_addr, pend_addr);
        check("req_hold_burst", o_rd_burstcount, pend_burst);
      end
      if (filt_pend) begin
        check("filter_hold_valid", o_filter_valid, 1'b1);
        check("filter_hold_data", o_filter_data, pend_data);
      end
      if (o_rd_valid && i_rd_ready) begin
        got_req_addr.push_back(o_rd_addr);
        got_req_burst.push_back(int'(o_rd_burstcount));
        for (int j = 0; j < int'(o_rd_burstcount); j++) resp_q.push_back(o_rd_addr + AW'(j * WB));
        outstanding += int'(o_rd_burstcount);
        check("inflight_within_fifo", (outstanding <= DEPTH), 1'b1);
      end
      if (i_rd_valid) fifo_cnt++;
      if (o_filter_valid && i_filter_ready) begin
        got_word.push_back(o_filter_data);
        outstanding--;
        fifo_cnt--;
        last_pop_cyc = cyc;
      end
      req_pend   = o_rd_valid && !i_rd_ready;
      pend_addr  = o_rd_addr;
      pend_burst = o_rd_burstcount;
      filt_pend  = o_filter_valid && !i_filter_ready;
      pend_data  = o_filter_data;
    end
  end

  // Memory responder and ready generators.
  initial begin
    i_rd_valid     = 1'b0;
    i_rd_data      = '0;
    i_rd_ready     = 1'b0;
    i_filter_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!i_aresetn) begin
        resp_q.delete();
        i_rd_valid = 1'b0;
        i_rd_data  = '0;
      end else if (resp_q.size() > 0 && (rsp_mode == 0 || $urandom_range(0, 2) != 0)) begin
        i_rd_valid = 1'b1;
        i_rd_data  = data_of(resp_q.pop_front());
      end else begin
        i_rd_valid = 1'b0;
        i_rd_data  = '0;
      end
      i_rd_ready = (rd_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      case (filt_mode)
        0:       i_filter_ready = 1'b1;
        1:       i_filter_ready = ($urandom_range(0, 2) != 0);
        default: i_filter_ready = 1'b0;
      endcase
    end
  end

  function automatic int sum_bursts();
    int s = 0;
    foreach (got_req_burst[i]) s += got_req_burst[i];
    return s;
  endfunction

  task automatic start_desc(input logic [AW-1:0] base, input int nw, input int rep);
    int k;
    int off;
    int b;
    got_req_addr.delete();
    got_req_burst.delete();
    got_word.delete();
    exp_req_addr.delete();
    exp_req_burst.delete();
    exp_word.delete();
    for (int p = 0; p <= rep; p++) begin
      off = 0;
      while (off < nw) begin
        b = (nw - off < int'(MAXB)) ? nw - off : int'(MAXB);
        exp_req_addr.push_back(base + AW'(off * WB));
        exp_req_burst.push_back(b);
        off += b;
      end
      for (int i = 0; i < nw; i++) exp_word.push_back(data_of(base + AW'(i * WB)));
    end
    k = 0;
    while (!o_config_ready && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("cfg_ready_wait", o_config_ready, 1'b1);
    i_config_data        = '0;
    i_config_data[31:0]  = base;
    i_config_data[63:32] = nw[31:0];
    i_config_data[79:64] = rep[15:0];
    i_config_valid       = 1'b1;
    @(posedge clk);
    #1;
    i_config_valid = 1'b0;
    if (nw != 0) begin
      check("accept_busy", o_busy, 1'b1);
      check("accept_cfg_ready", o_config_ready, 1'b0);
      check("first_req_valid", o_rd_valid, 1'b1);
      check("first_req_addr", o_rd_addr, base);
      check("first_req_burst", o_rd_burstcount, exp_req_burst[0]);
    end else begin
      check("empty_busy", o_busy, 1'b0);
      check("empty_cfg_ready", o_config_ready, 1'b1);
      check("empty_rd_valid", o_rd_valid, 1'b0);
    end
  endtask

  task automatic finish_desc();
    int k = 0;
    int busy_fall_cyc;
    int n;
    while (o_busy && k < 20000) begin
      @(posedge clk);
      #1;
      k++;
    end
    busy_fall_cyc = cyc;
    check("busy_timeout", o_busy, 1'b0);
    check("idle_cfg_ready", o_config_ready, 1'b1);
    check("busy_falls_on_last_pop", busy_fall_cyc, last_pop_cyc + 1);
    check("req_count", got_req_addr.size(), exp_req_addr.size());
    n = (got_req_addr.size() < exp_req_addr.size()) ? got_req_addr.size() : exp_req_addr.size();
    for (int i = 0; i < n; i++) begin
      check("req_addr", got_req_addr[i], exp_req_addr[i]);
      check("req_burst", got_req_burst[i], exp_req_burst[i]);
    end
    check("word_count", got_word.size(), exp_word.size());
    n = (got_word.size() < exp_word.size()) ? got_word.size() : exp_word.size();
    for (int i = 0; i < n; i++) check("word_data", got_word[i], exp_word[i]);
    check("outstanding_zero", outstanding, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_cfg_ready", o_config_ready, 1'b0);
    check("rst_rd_valid", o_rd_valid, 1'b0);
    check("rst_filter_valid", o_filter_valid, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_rd_addr", o_rd_addr, '0);
    check("rst_burstcount", o_rd_burstcount, '0);
    check("rst_filter_data", o_filter_data, '0);
  endtask

  initial begin
    logic [AW-1:0] base;
    salt           = $urandom;
    i_aresetn      = 1'b0;
    i_config_valid = 1'b0;
    i_config_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    i_aresetn = 1'b1;
    check("cfg_ready_after_release", o_config_ready, 1'b0);
    @(posedge clk);
    #1;
    check("cfg_ready_one_cycle_later", o_config_ready, 1'b1);

    // Two requests {0x1000,4},{0x1100,1}, all handshakes ready.
    start_desc(32'h0000_1000, 5, 0);
    finish_desc();

    // Empty descriptor: no requests at all.
    start_desc(32'h0000_2000, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("empty_no_req", o_rd_valid, 1'b0);
      check("empty_still_ready", o_config_ready, 1'b1);
    end
    check("empty_req_count", got_req_addr.size(), 0);

    // Three passes of three words.
    start_desc(32'h0002_0000, 3, 2);
    finish_desc();

    // Output held off: requests stop at FIFO capacity, then everything drains.
    filt_mode = 2;
    rsp_mode  = 1;
    start_desc(32'h0004_0000, 100, 0);
    repeat (300) @(posedge clk);
    #1;
    check("bp_words_requested", sum_bursts(), DEPTH);
    check("bp_no_pops", got_word.size(), 0);
    check("bp_rd_valid_low", o_rd_valid, 1'b0);
    check("bp_filter_valid", o_filter_valid, 1'b1);
    filt_mode = 1;
    finish_desc();

    // Reset mid-issue; credits must have fully returned, so 64 words go out first.
    filt_mode = 2;
    rd_mode   = 1;
    start_desc(32'h0008_0000, 200, 0);
    repeat (250) @(posedge clk);
    #1;
    check("pre_reset_words_requested", sum_bursts(), DEPTH);
    i_aresetn = 1'b0;
    #2;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    #1;
    i_aresetn = 1'b1;
    filt_mode = 0;
    start_desc(32'h000A_0000, 9, 1);
    finish_desc();

    // Randomized descriptors and handshakes; the first one wraps the address space.
    rd_mode   = 1;
    filt_mode = 1;
    rsp_mode  = 1;
    for (int t = 0; t < 6; t++) begin
      base = (t == 0) ? 32'hFFFF_FF80 : ($urandom & ~32'(WB - 1));
      start_desc(base, (t == 0) ? 6 : $urandom_range(1, 40), $urandom_range(0, 3));
      finish_desc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
